// File: rtl/arf_commit_rename_pkg.sv
// Shared constants and types for the architectural register file / rename table.
// Optional same-cycle commit bypass on the read ports: ARF_COMMIT_BYPASS_EN.
package arf_commit_rename_pkg;
    localparam int NUM_REGS  = 8;
    localparam int DATA_W    = 16;
    localparam int TAG_W     = 4;
    localparam int REG_IDX_W = 3;
    localparam int ROB_DEPTH = 16;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [TAG_W-1:0]     tag_t;

    // A slot touches register idx only when valid and idx is not the hardwired-zero R0.
    function automatic logic slot_hits(input logic valid, input reg_idx_t dest, input reg_idx_t idx);
        return valid && (dest == idx) && (idx != 3'd0);
    endfunction
endpackage

// File: rtl/arf_commit_rename_if.sv
// Commit, rename, flush and lookup bundle between ROB/dispatch (master) and the ARF (slave).
interface arf_commit_rename_if;
    import arf_commit_rename_pkg::*;

    logic     cm_valid_0, cm_valid_1;
    reg_idx_t cm_dest_0, cm_dest_1;
    data_t    cm_value_0, cm_value_1;
    tag_t     cm_tag_0, cm_tag_1;
    logic     rn_valid_0, rn_valid_1;
    reg_idx_t rn_dest_0, rn_dest_1;
    tag_t     rn_tag_0, rn_tag_1;
    logic     flush;
    reg_idx_t rd_src_0, rd_src_1, rd_src_2, rd_src_3;
    data_t    rd_data_0, rd_data_1, rd_data_2, rd_data_3;
    logic     rd_busy_0, rd_busy_1, rd_busy_2, rd_busy_3;
    tag_t     rd_tag_0, rd_tag_1, rd_tag_2, rd_tag_3;
    data_t    arf_data_1, arf_data_2, arf_data_3, arf_data_4, arf_data_5, arf_data_6, arf_data_7;

    modport master (
        output cm_valid_0, cm_valid_1, cm_dest_0, cm_dest_1, cm_value_0, cm_value_1, cm_tag_0, cm_tag_1,
        output rn_valid_0, rn_valid_1, rn_dest_0, rn_dest_1, rn_tag_0, rn_tag_1, flush,
        output rd_src_0, rd_src_1, rd_src_2, rd_src_3,
        input  rd_data_0, rd_data_1, rd_data_2, rd_data_3, rd_busy_0, rd_busy_1, rd_busy_2, rd_busy_3,
        input  rd_tag_0, rd_tag_1, rd_tag_2, rd_tag_3,
        input  arf_data_1, arf_data_2, arf_data_3, arf_data_4, arf_data_5, arf_data_6, arf_data_7
    );

    modport slave (
        input  cm_valid_0, cm_valid_1, cm_dest_0, cm_dest_1, cm_value_0, cm_value_1, cm_tag_0, cm_tag_1,
        input  rn_valid_0, rn_valid_1, rn_dest_0, rn_dest_1, rn_tag_0, rn_tag_1, flush,
        input  rd_src_0, rd_src_1, rd_src_2, rd_src_3,
        output rd_data_0, rd_data_1, rd_data_2, rd_data_3, rd_busy_0, rd_busy_1, rd_busy_2, rd_busy_3,
        output rd_tag_0, rd_tag_1, rd_tag_2, rd_tag_3,
        output arf_data_1, arf_data_2, arf_data_3, arf_data_4, arf_data_5, arf_data_6, arf_data_7
    );
endinterface

// File: rtl/arf_read_port.sv
// One source-operand lookup: value/busy/tag mux with optional commit bypass (ARF_COMMIT_BYPASS_EN).
module arf_read_port
    import arf_commit_rename_pkg::*;
(
    input  reg_idx_t                          src,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_data,
    input  logic [NUM_REGS-1:0]               regs_busy,
    input  logic [NUM_REGS-1:0][TAG_W-1:0]    regs_tag,
`ifdef ARF_COMMIT_BYPASS_EN
    input  logic     cm_valid_0,
    input  logic     cm_valid_1,
    input  reg_idx_t cm_dest_0,
    input  reg_idx_t cm_dest_1,
    input  data_t    cm_value_0,
    input  data_t    cm_value_1,
    input  tag_t     cm_tag_0,
    input  tag_t     cm_tag_1,
    input  logic     rn_valid_0,
    input  logic     rn_valid_1,
    input  reg_idx_t rn_dest_0,
    input  reg_idx_t rn_dest_1,
`endif
    output data_t    data,
    output logic     busy,
    output tag_t     tag
);
    // Lookup mux; R0 is forced to zero regardless of stored state.
    always_comb begin
        data = 16'h0000;
        busy = 1'b0;
        tag  = 4'h0;
        if (src != 3'd0) begin
            data = regs_data[src];
            busy = regs_busy[src];
            tag  = regs_tag[src];
`ifdef ARF_COMMIT_BYPASS_EN
            if (slot_hits(cm_valid_1, cm_dest_1, src)) begin
                data = cm_value_1;
            end else if (slot_hits(cm_valid_0, cm_dest_0, src)) begin
                data = cm_value_0;
            end else begin
                data = regs_data[src];
            end
            // A same-cycle rename keeps the register busy even if its producer retires now.
            if (((slot_hits(cm_valid_0, cm_dest_0, src) && (regs_tag[src] == cm_tag_0)) ||
                 (slot_hits(cm_valid_1, cm_dest_1, src) && (regs_tag[src] == cm_tag_1))) &&
                !slot_hits(rn_valid_0, rn_dest_0, src) && !slot_hits(rn_valid_1, rn_dest_1, src)) begin
                busy = 1'b0;
            end else begin
                busy = regs_busy[src];
            end
`endif
        end else begin
            data = 16'h0000;
        end
    end
endmodule

// File: rtl/arf_commit_rename.sv
// Architectural register file plus busy/tag rename table: two commits, two renames, four lookups.
// Optional same-cycle commit bypass on lookups: ARF_COMMIT_BYPASS_EN.
module arf_commit_rename
    import arf_commit_rename_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    arf_commit_rename_if.slave bus
);
    logic [NUM_REGS-1:0][DATA_W-1:0] data_r;
    logic [NUM_REGS-1:0]             busy_r;
    logic [NUM_REGS-1:0][TAG_W-1:0]  tag_r;

    // Commit writes, busy set/clear and tag capture; entry 0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= '0;
            busy_r <= '0;
            tag_r  <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (slot_hits(bus.cm_valid_1, bus.cm_dest_1, reg_idx_t'(i))) begin
                    data_r[i] <= bus.cm_value_1;
                end else if (slot_hits(bus.cm_valid_0, bus.cm_dest_0, reg_idx_t'(i))) begin
                    data_r[i] <= bus.cm_value_0;
                end else begin
                    data_r[i] <= data_r[i];
                end

                // Younger rename slot wins; any rename overrides a retiring producer's clear.
                if (bus.flush) begin
                    busy_r[i] <= 1'b0;
                end else if (slot_hits(bus.rn_valid_1, bus.rn_dest_1, reg_idx_t'(i))) begin
                    busy_r[i] <= 1'b1;
                    tag_r[i]  <= bus.rn_tag_1;
                end else if (slot_hits(bus.rn_valid_0, bus.rn_dest_0, reg_idx_t'(i))) begin
                    busy_r[i] <= 1'b1;
                    tag_r[i]  <= bus.rn_tag_0;
                end else if ((slot_hits(bus.cm_valid_0, bus.cm_dest_0, reg_idx_t'(i)) && (tag_r[i] == bus.cm_tag_0)) ||
                             (slot_hits(bus.cm_valid_1, bus.cm_dest_1, reg_idx_t'(i)) && (tag_r[i] == bus.cm_tag_1))) begin
                    busy_r[i] <= 1'b0;
                end else begin
                    busy_r[i] <= busy_r[i];
                end
            end
        end
    end

    reg_idx_t src_s   [4];
    data_t    rdata_s [4];
    logic     rbusy_s [4];
    tag_t     rtag_s  [4];

    assign src_s[0] = bus.rd_src_0;
    assign src_s[1] = bus.rd_src_1;
    assign src_s[2] = bus.rd_src_2;
    assign src_s[3] = bus.rd_src_3;

    for (genvar p = 0; p < 4; p++) begin : g_rd
        arf_read_port u_rd (
            .src        (src_s[p]),
            .regs_data  (data_r),
            .regs_busy  (busy_r),
            .regs_tag   (tag_r),
`ifdef ARF_COMMIT_BYPASS_EN
            .cm_valid_0 (bus.cm_valid_0),
            .cm_valid_1 (bus.cm_valid_1),
            .cm_dest_0  (bus.cm_dest_0),
            .cm_dest_1  (bus.cm_dest_1),
            .cm_value_0 (bus.cm_value_0),
            .cm_value_1 (bus.cm_value_1),
            .cm_tag_0   (bus.cm_tag_0),
            .cm_tag_1   (bus.cm_tag_1),
            .rn_valid_0 (bus.rn_valid_0),
            .rn_valid_1 (bus.rn_valid_1),
            .rn_dest_0  (bus.rn_dest_0),
            .rn_dest_1  (bus.rn_dest_1),
`endif
            .data       (rdata_s[p]),
            .busy       (rbusy_s[p]),
            .tag        (rtag_s[p])
        );
    end

    assign bus.rd_data_0 = rdata_s[0];
    assign bus.rd_data_1 = rdata_s[1];
    assign bus.rd_data_2 = rdata_s[2];
    assign bus.rd_data_3 = rdata_s[3];
    assign bus.rd_busy_0 = rbusy_s[0];
    assign bus.rd_busy_1 = rbusy_s[1];
    assign bus.rd_busy_2 = rbusy_s[2];
    assign bus.rd_busy_3 = rbusy_s[3];
    assign bus.rd_tag_0  = rtag_s[0];
    assign bus.rd_tag_1  = rtag_s[1];
    assign bus.rd_tag_2  = rtag_s[2];
    assign bus.rd_tag_3  = rtag_s[3];

    assign bus.arf_data_1 = data_r[1];
    assign bus.arf_data_2 = data_r[2];
    assign bus.arf_data_3 = data_r[3];
    assign bus.arf_data_4 = data_r[4];
    assign bus.arf_data_5 = data_r[5];
    assign bus.arf_data_6 = data_r[6];
    assign bus.arf_data_7 = data_r[7];
endmodule

// File: tb/tb_arf_commit_rename.sv
// Directed + scored bench for arf_commit_rename; reference model tracks architectural state per register.
module tb_arf_commit_rename;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    arf_commit_rename_if bus ();

    arf_commit_rename dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] m_data [8];
    logic        m_busy [8];
    logic [3:0]  m_tag  [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected lookup result from the model and this cycle's inputs.
    task automatic model_read(input logic [2:0] s, output logic [15:0] d, output logic b, output logic [3:0] t);
        d = 16'h0; b = 1'b0; t = 4'h0;
        if (s != 3'd0) begin
            d = m_data[s]; b = m_busy[s]; t = m_tag[s];
`ifdef ARF_COMMIT_BYPASS_EN
            begin
                logic hit0, hit1, ren;
                hit0 = bus.cm_valid_0 && bus.cm_dest_0 == s;
                hit1 = bus.cm_valid_1 && bus.cm_dest_1 == s;
                ren  = (bus.rn_valid_0 && bus.rn_dest_0 == s) || (bus.rn_valid_1 && bus.rn_dest_1 == s);
                if (hit1) d = bus.cm_value_1;
                else if (hit0) d = bus.cm_value_0;
                if (((hit0 && m_tag[s] == bus.cm_tag_0) || (hit1 && m_tag[s] == bus.cm_tag_1)) && !ren) b = 1'b0;
            end
`endif
        end
    endtask

    // Model update: retire in program order, then apply renames in age order (or flush).
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int r = 0; r < 8; r++) begin
                    m_data[r] = 16'h0; m_busy[r] = 1'b0; m_tag[r] = 4'h0;
                end
            end else begin
                logic clr [8];
                for (int r = 0; r < 8; r++) clr[r] = 1'b0;
                if (bus.cm_valid_0 && bus.cm_dest_0 != 3'd0) begin
                    m_data[bus.cm_dest_0] = bus.cm_value_0;
                    if (m_tag[bus.cm_dest_0] == bus.cm_tag_0) clr[bus.cm_dest_0] = 1'b1;
                end
                if (bus.cm_valid_1 && bus.cm_dest_1 != 3'd0) begin
                    m_data[bus.cm_dest_1] = bus.cm_value_1;
                    if (m_tag[bus.cm_dest_1] == bus.cm_tag_1) clr[bus.cm_dest_1] = 1'b1;
                end
                for (int r = 0; r < 8; r++) if (clr[r]) m_busy[r] = 1'b0;
                if (bus.flush) begin
                    for (int r = 0; r < 8; r++) m_busy[r] = 1'b0;
                end else begin
                    if (bus.rn_valid_0 && bus.rn_dest_0 != 3'd0) begin
                        m_busy[bus.rn_dest_0] = 1'b1; m_tag[bus.rn_dest_0] = bus.rn_tag_0;
                    end
                    if (bus.rn_valid_1 && bus.rn_dest_1 != 3'd0) begin
                        m_busy[bus.rn_dest_1] = 1'b1; m_tag[bus.rn_dest_1] = bus.rn_tag_1;
                    end
                end
            end
        end
    end

    // Every falling edge: all lookups and debug views against the model.
    initial begin
        forever begin
            logic [2:0]  s [4];
            logic [15:0] a_d [4];
            logic        a_b [4];
            logic [3:0]  a_t [4];
            logic [15:0] arf [8];
            logic [15:0] ed;
            logic        eb;
            logic [3:0]  et;
            @(negedge clk);
            s[0] = bus.rd_src_0; s[1] = bus.rd_src_1; s[2] = bus.rd_src_2; s[3] = bus.rd_src_3;
            a_d[0] = bus.rd_data_0; a_d[1] = bus.rd_data_1; a_d[2] = bus.rd_data_2; a_d[3] = bus.rd_data_3;
            a_b[0] = bus.rd_busy_0; a_b[1] = bus.rd_busy_1; a_b[2] = bus.rd_busy_2; a_b[3] = bus.rd_busy_3;
            a_t[0] = bus.rd_tag_0;  a_t[1] = bus.rd_tag_1;  a_t[2] = bus.rd_tag_2;  a_t[3] = bus.rd_tag_3;
            arf[0] = 16'h0;          arf[1] = bus.arf_data_1; arf[2] = bus.arf_data_2; arf[3] = bus.arf_data_3;
            arf[4] = bus.arf_data_4; arf[5] = bus.arf_data_5; arf[6] = bus.arf_data_6; arf[7] = bus.arf_data_7;
            for (int p = 0; p < 4; p++) begin
                model_read(s[p], ed, eb, et);
                chk($sformatf("rd_data_%0d", p), 32'(a_d[p]), 32'(ed));
                chk($sformatf("rd_busy_%0d", p), 32'(a_b[p]), 32'(eb));
                chk($sformatf("rd_tag_%0d", p),  32'(a_t[p]), 32'(et));
            end
            for (int r = 1; r < 8; r++) chk($sformatf("arf_data_%0d", r), 32'(arf[r]), 32'(m_data[r]));
        end
    end

    task automatic idle();
        bus.cm_valid_0 = 1'b0; bus.cm_valid_1 = 1'b0;
        bus.rn_valid_0 = 1'b0; bus.rn_valid_1 = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input int slot, input logic [2:0] d, input logic [3:0] t, input logic [15:0] v);
        if (slot == 0) begin
            bus.cm_valid_0 = 1'b1; bus.cm_dest_0 = d; bus.cm_tag_0 = t; bus.cm_value_0 = v;
        end else begin
            bus.cm_valid_1 = 1'b1; bus.cm_dest_1 = d; bus.cm_tag_1 = t; bus.cm_value_1 = v;
        end
    endtask

    task automatic rename(input int slot, input logic [2:0] d, input logic [3:0] t);
        if (slot == 0) begin
            bus.rn_valid_0 = 1'b1; bus.rn_dest_0 = d; bus.rn_tag_0 = t;
        end else begin
            bus.rn_valid_1 = 1'b1; bus.rn_dest_1 = d; bus.rn_tag_1 = t;
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        bus.cm_dest_0 = 3'd0; bus.cm_dest_1 = 3'd0; bus.cm_tag_0 = 4'h0; bus.cm_tag_1 = 4'h0;
        bus.cm_value_0 = 16'h0; bus.cm_value_1 = 16'h0;
        bus.rn_dest_0 = 3'd0; bus.rn_dest_1 = 3'd0; bus.rn_tag_0 = 4'h0; bus.rn_tag_1 = 4'h0;
        bus.rd_src_0 = 3'd0; bus.rd_src_1 = 3'd0; bus.rd_src_2 = 3'd0; bus.rd_src_3 = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // Rename R6 tag 5, then its commit retires it.
        rename(0, 3'd6, 4'd5); step(); idle(); step();
        bus.rd_src_0 = 3'd6; #1;
        chk("r6_busy_after_rename", 32'(bus.rd_busy_0), 32'd1);
        chk("r6_tag_after_rename", 32'(bus.rd_tag_0), 32'd5);
        commit(0, 3'd6, 4'd5, 16'h0014); step(); idle();
        chk("r6_data_after_commit", 32'(bus.arf_data_6), 32'h0014);
        chk("r6_busy_after_commit", 32'(bus.rd_busy_0), 32'd0);

        // Stale commit leaves the younger producer's busy/tag intact.
        rename(0, 3'd4, 4'd2); step(); idle();
        rename(0, 3'd4, 4'd7); step(); idle();
        commit(0, 3'd4, 4'd2, 16'h0003); step(); idle();
        bus.rd_src_1 = 3'd4; #1;
        chk("r4_stale_data", 32'(bus.rd_data_1), 32'h0003);
        chk("r4_stale_busy", 32'(bus.rd_busy_1), 32'd1);
        chk("r4_stale_tag", 32'(bus.rd_tag_1), 32'd7);
        commit(1, 3'd4, 4'd7, 16'h0008); step(); idle();
        chk("r4_final_data", 32'(bus.rd_data_1), 32'h0008);
        chk("r4_final_busy", 32'(bus.rd_busy_1), 32'd0);

        // Dual commit to the same register: slot 1 is younger.
        commit(0, 3'd5, 4'd0, 16'h1111); commit(1, 3'd5, 4'd1, 16'hFFFE); step(); idle();
        chk("r5_dual_commit", 32'(bus.arf_data_5), 32'hFFFE);

        // Rename beats a matching same-cycle commit.
        rename(0, 3'd2, 4'd3); step(); idle();
        commit(0, 3'd2, 4'd3, 16'h0022); rename(0, 3'd2, 4'd9); step(); idle();
        bus.rd_src_2 = 3'd2; #1;
        chk("r2_rename_wins_busy", 32'(bus.rd_busy_2), 32'd1);
        chk("r2_rename_wins_tag", 32'(bus.rd_tag_2), 32'd9);
        chk("r2_data", 32'(bus.rd_data_2), 32'h0022);

        // R0 ignores commits and renames.
        commit(0, 3'd0, 4'd0, 16'h1234); rename(1, 3'd0, 4'd12); step(); idle();
        bus.rd_src_3 = 3'd0; #1;
        chk("r0_data", 32'(bus.rd_data_3), 32'h0);
        chk("r0_busy", 32'(bus.rd_busy_3), 32'd0);
        chk("r0_tag", 32'(bus.rd_tag_3), 32'd0);

        // Flush: busy cleared, commit data lands, same-cycle rename dropped.
        rename(0, 3'd1, 4'd1); rename(1, 3'd7, 4'd4); step(); idle();
        bus.flush = 1'b1; commit(0, 3'd7, 4'd0, 16'h1234); rename(0, 3'd3, 4'd6); step(); idle();
        bus.rd_src_0 = 3'd1; bus.rd_src_1 = 3'd7; bus.rd_src_2 = 3'd3; #1;
        chk("flush_r1_busy", 32'(bus.rd_busy_0), 32'd0);
        chk("flush_r7_busy", 32'(bus.rd_busy_1), 32'd0);
        chk("flush_r3_rename_dropped", 32'(bus.rd_busy_2), 32'd0);
        chk("flush_r7_data", 32'(bus.arf_data_7), 32'h1234);

        // Same-cycle read of a committing register.
        bus.rd_src_0 = 3'd1; commit(0, 3'd1, 4'd1, 16'h0010); #1;
`ifdef ARF_COMMIT_BYPASS_EN
        chk("bypass_same_cycle", 32'(bus.rd_data_0), 32'h0010);
`else
        chk("no_bypass_same_cycle", 32'(bus.rd_data_0), 32'h0000);
`endif
        step(); idle();
        chk("commit_next_cycle", 32'(bus.rd_data_0), 32'h0010);

        // Mixed traffic scored by the model.
        for (int k = 0; k < 60; k++) begin
            bus.cm_valid_0 = 1'($urandom_range(0, 1)); bus.cm_dest_0 = 3'($urandom); bus.cm_tag_0 = 4'($urandom);
            bus.cm_value_0 = 16'($urandom);
            bus.cm_valid_1 = 1'($urandom_range(0, 1)); bus.cm_dest_1 = 3'($urandom); bus.cm_tag_1 = 4'($urandom);
            bus.cm_value_1 = 16'($urandom);
            bus.rn_valid_0 = 1'($urandom_range(0, 1)); bus.rn_dest_0 = 3'($urandom); bus.rn_tag_0 = 4'($urandom);
            bus.rn_valid_1 = 1'($urandom_range(0, 1)); bus.rn_dest_1 = 3'($urandom); bus.rn_tag_1 = 4'($urandom);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.rd_src_0 = 3'($urandom); bus.rd_src_1 = 3'($urandom);
            bus.rd_src_2 = 3'($urandom); bus.rd_src_3 = 3'($urandom);
            step();
        end
        idle();
        step();

        // Async reset mid-run with R3 busy and holding 0x000A.
        rename(0, 3'd3, 4'd10); step(); idle();
        commit(0, 3'd3, 4'd11, 16'h000A); step(); idle();
        bus.rd_src_3 = 3'd3; #1;
        chk("r3_pre_reset_data", 32'(bus.rd_data_3), 32'h000A);
        chk("r3_pre_reset_busy", 32'(bus.rd_busy_3), 32'd1);
        rst = 1'b0; #1;
        chk("reset_rd_data_3", 32'(bus.rd_data_3), 32'h0);
        chk("reset_rd_busy_3", 32'(bus.rd_busy_3), 32'd0);
        chk("reset_rd_tag_3", 32'(bus.rd_tag_3), 32'd0);
        chk("reset_arf_data_3", 32'(bus.arf_data_3), 32'h0);
        step();
        rst = 1'b1;
        step();
        chk("post_reset_arf_data_3", 32'(bus.arf_data_3), 32'h0);
        chk("post_reset_arf_data_7", 32'(bus.arf_data_7), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
